// File: rtl/sum_1to10_control_unit.sv
// Control unit for the sum-of-1-to-10 dedicated processor.
// Runs the init/compare/add/increment loop on the datapath and
// hands the committed sum to the host with a done/ack handshake.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         run request, sampled only in IDLE
//   ack           host acknowledge, releases DONE or ERROR
//   not_iLe10     datapath status, 1 when i > 10
//   sumSrcSel     sum mux select (0: const 0, 1: adder)
//   iSrcSel       i mux select (0: const 0, 1: adder)
//   sumLoad       sum register load enable
//   iLoad         i register load enable
//   adderSrcSel   adder operand A (0: sum, 1: const 1)
//   OutLoad       output register load enable
//   busy          high while the loop is running
//   done          high in DONE
//   err           high in ERROR (iteration watchdog tripped)
//   iter_count    completed loop iterations, saturating
//   cycle_count   busy cycles in the run, saturating
module sum_1to10_control_unit #(
   parameter int unsigned MAX_ITER = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       ack,
   input  logic       not_iLe10,
   output logic       sumSrcSel,
   output logic       iSrcSel,
   output logic       sumLoad,
   output logic       iLoad,
   output logic       adderSrcSel,
   output logic       OutLoad,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] iter_count,
   output logic [7:0] cycle_count
);

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      CHECK,
      ADD,
      INC,
      OUTPUT,
      DONE,
      ERROR
   } state_t;

   state_t state;
   state_t state_nxt;

   logic iter_limit;

   // Watchdog compare is done at full width so any MAX_ITER is legal;
   // values above 255 can never match the saturating counter.
   assign iter_limit = (32'(iter_count) == MAX_ITER);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = INIT;
            end
         end
         INIT: begin
            state_nxt = CHECK;
         end
         CHECK: begin
            // Loop exit has priority over the watchdog.
            if (not_iLe10) begin
               state_nxt = OUTPUT;
            end else if (iter_limit) begin
               state_nxt = ERROR;
            end else begin
               state_nxt = ADD;
            end
         end
         ADD: begin
            state_nxt = INC;
         end
         INC: begin
            state_nxt = CHECK;
         end
         OUTPUT: begin
            state_nxt = DONE;
         end
         DONE: begin
            if (ack) begin
               state_nxt = IDLE;
            end
         end
         ERROR: begin
            if (ack) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      sumSrcSel   = 1'b0;
      iSrcSel     = 1'b0;
      sumLoad     = 1'b0;
      iLoad       = 1'b0;
      adderSrcSel = 1'b0;
      OutLoad     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      unique case (state)
         INIT: begin
            sumLoad = 1'b1;
            iLoad   = 1'b1;
            busy    = 1'b1;
         end
         CHECK: begin
            busy = 1'b1;
         end
         ADD: begin
            sumSrcSel = 1'b1;
            sumLoad   = 1'b1;
            busy      = 1'b1;
         end
         INC: begin
            adderSrcSel = 1'b1;
            iSrcSel     = 1'b1;
            iLoad       = 1'b1;
            busy        = 1'b1;
         end
         OUTPUT: begin
            OutLoad = 1'b1;
            busy    = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         ERROR: begin
            err = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Counters clear when a run is accepted and hold otherwise,
   // so the host can read them after DONE or ERROR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iter_count  <= 8'd0;
         cycle_count <= 8'd0;
      end else if (state == IDLE && start) begin
         iter_count  <= 8'd0;
         cycle_count <= 8'd0;
      end else begin
         if (busy && cycle_count != 8'hFF) begin
            cycle_count <= cycle_count + 8'd1;
         end
         if (state == INC && iter_count != 8'hFF) begin
            iter_count <= iter_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_sum_1to10_control_unit.sv
// Bench for sum_1to10_control_unit with a behavioural datapath.
// Runs a table of normal runs, a mid-loop reset and a watchdog run.
module tb_sum_1to10_control_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   // Default-parameter instance
   logic       start = 1'b0;
   logic       ack = 1'b0;
   logic       nle;
   logic       sum_sel, i_sel, sum_ld, i_ld, add_sel, out_ld;
   logic       busy, done, err;
   logic [7:0] iter_cnt, cyc_cnt;
   logic [7:0] sum_r, i_r, out_r, add_a;
   logic [8:0] vec;

   // MAX_ITER = 5 instance
   logic       start_b = 1'b0;
   logic       ack_b = 1'b0;
   logic       nle_b;
   logic       sum_sel_b, i_sel_b, sum_ld_b, i_ld_b, add_sel_b, out_ld_b;
   logic       busy_b, done_b, err_b;
   logic [7:0] iter_b, cyc_b;
   logic [7:0] sum_rb, i_rb, out_rb, add_ab;

   sum_1to10_control_unit dut (
      .clk(clk), .rst(rst), .start(start), .ack(ack),
      .not_iLe10(nle), .sumSrcSel(sum_sel), .iSrcSel(i_sel),
      .sumLoad(sum_ld), .iLoad(i_ld), .adderSrcSel(add_sel),
      .OutLoad(out_ld), .busy(busy), .done(done), .err(err),
      .iter_count(iter_cnt), .cycle_count(cyc_cnt)
   );

   sum_1to10_control_unit #(.MAX_ITER(5)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .ack(ack_b),
      .not_iLe10(nle_b), .sumSrcSel(sum_sel_b), .iSrcSel(i_sel_b),
      .sumLoad(sum_ld_b), .iLoad(i_ld_b), .adderSrcSel(add_sel_b),
      .OutLoad(out_ld_b), .busy(busy_b), .done(done_b), .err(err_b),
      .iter_count(iter_b), .cycle_count(cyc_b)
   );

   // Datapath models: adder = (adderSrcSel ? 1 : sum) + i
   assign add_a = (add_sel ? 8'd1 : sum_r) + i_r;
   assign nle   = (i_r > 8'd10);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_r <= 8'd0; i_r <= 8'd0; out_r <= 8'd0;
      end else begin
         if (sum_ld) sum_r <= sum_sel ? add_a : 8'd0;
         if (i_ld) i_r <= i_sel ? add_a : 8'd0;
         if (out_ld) out_r <= sum_r;
      end
   end

   assign add_ab = (add_sel_b ? 8'd1 : sum_rb) + i_rb;
   assign nle_b  = (i_rb > 8'd10);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_rb <= 8'd0; i_rb <= 8'd0; out_rb <= 8'd0;
      end else begin
         if (sum_ld_b) sum_rb <= sum_sel_b ? add_ab : 8'd0;
         if (i_ld_b) i_rb <= i_sel_b ? add_ab : 8'd0;
         if (out_ld_b) out_rb <= sum_rb;
      end
   end

   // {sumSrcSel,iSrcSel,sumLoad,iLoad,adderSrcSel,OutLoad,busy,done,err}
   assign vec = {sum_sel, i_sel, sum_ld, i_ld, add_sel,
                 out_ld, busy, done, err};

   localparam logic [8:0] V_IDLE  = 9'b000000000;
   localparam logic [8:0] V_INIT  = 9'b001100100;
   localparam logic [8:0] V_CHECK = 9'b000000100;
   localparam logic [8:0] V_ADD   = 9'b101000100;
   localparam logic [8:0] V_INC   = 9'b010110100;
   localparam logic [8:0] V_OUT   = 9'b000001100;
   localparam logic [8:0] V_DONE  = 9'b000000010;

   int errs = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] out;
      logic [7:0] iter;
      logic [7:0] cyc;
   } sb_t;

   typedef struct {
      bit extra;
      bit ack_ws;
      int ack_wait;
      int exp_done;
   } run_t;

   sb_t sbq[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Expected output vector in cycle c after the start edge.
   function automatic logic [8:0] exp_vec(input int c);
      if (c == 1) return V_INIT;
      if (c >= 2 && c <= 35) begin
         case ((c - 2) % 3)
            0: return V_CHECK;
            1: return V_ADD;
            default: return V_INC;
         endcase
      end
      if (c == 36) return V_OUT;
      return V_DONE;
   endfunction

   task automatic run(input run_t r);
      int  c;
      int  ol;
      bit  seen;
      sb_t e;
      @(negedge clk);
      start = 1'b1;
      ack = r.ack_ws;
      sbq.push_back('{out: 8'd55, iter: 8'd11, cyc: 8'd36});
      @(negedge clk);
      start = 1'b0;
      ack = 1'b0;
      c = 1;
      ol = 0;
      seen = 1'b0;
      while (!seen && c <= 60) begin
         chk("decode", 32'(vec), 32'(exp_vec(c)));
         if (sum_ld && i_ld && c != 1) chk("dual_load", c, 1);
         if (out_ld) begin
            ol++;
            chk("outload_cycle", c, 36);
         end
         if (done) begin
            seen = 1'b1;
            e = sbq.pop_front();
            chk("done_cycle", c, r.exp_done);
            chk("out", 32'(out_r), 32'(e.out));
            chk("iter_count", 32'(iter_cnt), 32'(e.iter));
            chk("cycle_count", 32'(cyc_cnt), 32'(e.cyc));
         end
         start = (r.extra && c >= 5 && c <= 20) ? c[0] : 1'b0;
         if (!seen) begin
            @(negedge clk);
            c++;
         end
      end
      start = 1'b0;
      if (!seen) chk("done_timeout", 0, 1);
      chk("outload_pulses", ol, 1);
      repeat (r.ack_wait) begin
         @(negedge clk);
         chk("done_hold", 32'(vec), 32'(V_DONE));
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("idle_after_ack", 32'(vec), 32'(V_IDLE));
      chk("iter_held", 32'(iter_cnt), 11);
      chk("cycle_held", 32'(cyc_cnt), 36);
   endtask

   run_t tbl[4];

   initial begin
      int  c;
      int  ol;
      bit  seen;

      tbl[0] = '{extra: 1'b0, ack_ws: 1'b0, ack_wait: 0,  exp_done: 37};
      tbl[1] = '{extra: 1'b0, ack_ws: 1'b0, ack_wait: 10, exp_done: 37};
      tbl[2] = '{extra: 1'b1, ack_ws: 1'b0, ack_wait: 2,  exp_done: 37};
      tbl[3] = '{extra: 1'b0, ack_ws: 1'b1, ack_wait: 3,  exp_done: 37};

      #2 rst = 1'b1;
      #1;
      chk("reset_vec", 32'(vec), 32'(V_IDLE));
      chk("reset_iter", 32'(iter_cnt), 0);
      chk("reset_cyc", 32'(cyc_cnt), 0);
      chk("reset_vec_b", 32'({busy_b, done_b, err_b, out_ld_b}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_stays", 32'(vec), 32'(V_IDLE));

      for (int k = 0; k < 4; k++) begin
         run(tbl[k]);
      end

      // Reset in ADD of the 4th iteration (cycle 12 after start).
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      chk("pre_reset_add", 32'(vec), 32'(V_ADD));
      chk("pre_reset_iter", 32'(iter_cnt), 3);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_vec", 32'(vec), 32'(V_IDLE));
      chk("async_rst_iter", 32'(iter_cnt), 0);
      chk("async_rst_cyc", 32'(cyc_cnt), 0);
      chk("async_rst_sum", 32'(sum_r), 0);
      @(negedge clk);
      rst = 1'b0;
      run(tbl[0]);

      // Watchdog run on the MAX_ITER = 5 instance.
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      c = 1;
      ol = 0;
      seen = 1'b0;
      while (!seen && c <= 60) begin
         if (out_ld_b) ol++;
         if (done_b) chk("wd_no_done", 1, 0);
         if (err_b) begin
            seen = 1'b1;
            chk("wd_err_cycle", c, 18);
            chk("wd_iter", 32'(iter_b), 5);
            chk("wd_cyc", 32'(cyc_b), 17);
            chk("wd_busy", 32'(busy_b), 0);
         end else begin
            @(negedge clk);
            c++;
         end
      end
      if (!seen) chk("wd_timeout", 0, 1);
      chk("wd_no_outload", ol, 0);
      repeat (3) begin
         start_b = 1'b1;
         @(negedge clk);
         chk("wd_err_hold", 32'(err_b), 1);
      end
      start_b = 1'b0;
      ack_b = 1'b1;
      @(negedge clk);
      ack_b = 1'b0;
      chk("wd_idle", 32'({busy_b, done_b, err_b}), 0);
      chk("wd_iter_held", 32'(iter_b), 5);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
